// File: rtl/pit_multi.sv
// Multi-channel programmable interval timer.
// Each channel is a WIDTH-bit up-counter that expires when COUNT reaches LIMIT,
// giving a period of LIMIT+1 timebase ticks, in periodic or one-shot mode.
// Register port: addr[ADDR_W-1:2] selects the channel, addr[1:0] the register
// (0 LIMIT, 1 CTRL, 2 COUNT, 3 STATUS). Reads return pre-write state one cycle later.
module pit_multi #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    // Address decode shared by every channel. The shift keeps the decode valid
    // even for a single-channel build where the channel field is empty.
    logic [ADDR_W-1:0] ch_sel;
    logic [1:0]        reg_sel;
    assign ch_sel  = addr >> 2;
    assign reg_sel = addr[1:0];

    // Per-channel state gathered for the read mux and interrupt logic
    logic [NUM_CH*WIDTH-1:0] limit_flat;
    logic [NUM_CH*WIDTH-1:0] count_flat;
    logic [NUM_CH-1:0]       en_vec;
    logic [NUM_CH-1:0]       periodic_vec;
    logic [NUM_CH-1:0]       ie_vec;
    logic [NUM_CH-1:0]       pending_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [WIDTH-1:0] limit_reg;
            logic [WIDTH-1:0] count_reg;
            logic             en_reg;
            logic             periodic_reg;
            logic             ie_reg;
            logic             pending_reg;
            logic             ch_hit;
            logic             wr_limit;
            logic             wr_ctrl;
            logic             wr_status;
            logic             tick;
            logic             expire;

            assign ch_hit    = (ch_sel == ADDR_W'(gi));
            assign wr_limit  = we & ch_hit & (reg_sel == 2'd0);
            assign wr_ctrl   = we & ch_hit & (reg_sel == 2'd1);
            assign wr_status = we & ch_hit & (reg_sel == 2'd3);

            // A LIMIT write restarts the count, and a CTRL write clearing en
            // freezes it, so neither may coincide with a counting step.
            assign tick   = clk_en & en_reg & ~wr_limit & ~(wr_ctrl & ~wdata[0]);
            assign expire = tick & (count_reg >= limit_reg);

            // LIMIT register and the counter (restart on LIMIT write or enable edge)
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    limit_reg <= '0;
                    count_reg <= '0;
                end else begin
                    if (wr_limit) begin
                        limit_reg <= wdata[WIDTH-1:0];
                        count_reg <= '0;
                    end else if (wr_ctrl && wdata[0] && !en_reg) begin
                        count_reg <= '0;
                    end else if (tick) begin
                        count_reg <= expire ? '0 : count_reg + WIDTH'(1);
                    end
                end
            end

            // CTRL bits; a one-shot channel drops en on its expiry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    en_reg       <= 1'b0;
                    periodic_reg <= 1'b0;
                    ie_reg       <= 1'b0;
                end else if (wr_ctrl) begin
                    en_reg       <= wdata[0];
                    periodic_reg <= wdata[1];
                    ie_reg       <= wdata[2];
                end else if (expire && !periodic_reg) begin
                    en_reg <= 1'b0;
                end
            end

            // Sticky pending flag: expiry has priority over a W1C in the same cycle
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pending_reg <= 1'b0;
                end else if (expire) begin
                    pending_reg <= 1'b1;
                end else if (wr_status && wdata[0]) begin
                    pending_reg <= 1'b0;
                end
            end

            assign limit_flat[gi*WIDTH +: WIDTH] = limit_reg;
            assign count_flat[gi*WIDTH +: WIDTH] = count_reg;
            assign en_vec[gi]       = en_reg;
            assign periodic_vec[gi] = periodic_reg;
            assign ie_vec[gi]       = ie_reg;
            assign pending_vec[gi]  = pending_reg;
        end
    endgenerate

    // Read mux over current (pre-write) state; unmapped channels read as zero
    logic [31:0] rd_next;
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == ADDR_W'(i)) begin
                case (reg_sel)
                    2'd0:    rd_next = 32'(limit_flat[i*WIDTH +: WIDTH]);
                    2'd1:    rd_next = {29'd0, ie_vec[i], periodic_vec[i], en_vec[i]};
                    2'd2:    rd_next = 32'(count_flat[i*WIDTH +: WIDTH]);
                    default: rd_next = {31'd0, pending_vec[i]};
                endcase
            end
        end
    end

    logic [31:0]       rdata_reg;
    logic              rvalid_reg;
    logic [NUM_CH-1:0] irq_vec_reg;
    logic              irq_reg;

    // Registered read response; rdata holds its last value between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= re;
            if (re) begin
                rdata_reg <= rd_next;
            end
        end
    end

    // Registered interrupt outputs, one cycle behind pending/ie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_vec_reg <= '0;
            irq_reg     <= 1'b0;
        end else begin
            irq_vec_reg <= pending_vec & ie_vec;
            irq_reg     <= |(pending_vec & ie_vec);
        end
    end

    assign rdata   = rdata_reg;
    assign rvalid  = rvalid_reg;
    assign irq_vec = irq_vec_reg;
    assign irq     = irq_reg;

endmodule

// File: tb/tb_pit_multi.sv
// Directed bench for pit_multi: a 4-channel instance for the main behaviour and a
// 3-channel instance sharing the same inputs for the unmapped-channel read.
module tb_pit_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;

    logic [31:0] rdata, rdata3;
    logic        rvalid, rvalid3;
    logic        irq, irq3;
    logic [3:0]  irq_vec;
    logic [2:0]  irq_vec3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pit_multi #(.NUM_CH(4), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .we(we), .re(re),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
        .irq(irq), .irq_vec(irq_vec)
    );

    pit_multi #(.NUM_CH(3), .WIDTH(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .we(we), .re(re),
        .addr(addr), .wdata(wdata), .rdata(rdata3), .rvalid(rvalid3),
        .irq(irq3), .irq_vec(irq_vec3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // All bus tasks start and end at a falling edge
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        re = 1'b1; addr = a;
        @(negedge clk);
        re = 1'b0;
        check(tag, rdata, exp);
    endtask

    initial begin
        // Reset for three cycles
        repeat (3) @(negedge clk);
        check("irq_in_reset", 32'(irq), 32'd0);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) rd($sformatf("reset_reg_%0d", a), 4'(a), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_irq_vec", 32'(irq_vec), 32'd0);

        // Periodic ch1, LIMIT=4, tick every cycle: expiry every 5 edges
        clk_en = 1'b1;
        wr(4'd4, 32'd4);
        wr(4'd5, 32'd7);
        repeat (5) @(negedge clk);
        check("per_before_irq", 32'(irq_vec), 32'd0);
        @(negedge clk);
        check("per_first_irq", 32'(irq_vec), 32'h2);
        wr(4'd7, 32'd1);
        check("per_irq_lag_w1c", 32'(irq), 32'd1);
        @(negedge clk);
        check("per_irq_dropped", 32'(irq), 32'd0);
        repeat (2) @(negedge clk);
        check("per_before_second", 32'(irq_vec), 32'd0);
        @(negedge clk);
        check("per_second_irq", 32'(irq_vec), 32'h2);
        wr(4'd5, 32'd0);
        wr(4'd7, 32'd1);

        // One-shot ch2, LIMIT=2, tick every third cycle
        clk_en = 1'b0;
        wr(4'd8, 32'd2);
        wr(4'd9, 32'd5);
        for (int k = 1; k <= 3; k++) begin
            clk_en = 1'b0;
            repeat (2) @(negedge clk);
            clk_en = 1'b1;
            @(negedge clk);
            if (k == 2) check("os_no_early_irq", 32'(irq_vec), 32'd0);
        end
        clk_en = 1'b0;
        @(negedge clk);
        check("os_irq_third_tick", 32'(irq_vec), 32'h4);
        rd("os_ctrl_after", 4'd9, 32'h4);
        rd("os_count_after", 4'd10, 32'd0);
        wr(4'd11, 32'd1);
        for (int k = 0; k < 50; k++) begin
            clk_en = 1'b0;
            repeat (2) @(negedge clk);
            clk_en = 1'b1;
            @(negedge clk);
        end
        clk_en = 1'b0;
        rd("os_count_held", 4'd10, 32'd0);
        rd("os_no_second", 4'd11, 32'd0);

        // Collision: W1C on the same edge as an expiry (ch2 LIMIT=0 periodic)
        clk_en = 1'b1;
        wr(4'd8, 32'd0);
        wr(4'd9, 32'd3);
        wr(4'd11, 32'd1);
        clk_en = 1'b0;
        rd("w1c_vs_expiry", 4'd11, 32'd1);
        wr(4'd11, 32'd1);
        rd("w1c_clears", 4'd11, 32'd0);

        // Collision: LIMIT write on the COUNT==LIMIT tick
        wr(4'd8, 32'd3);
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        clk_en = 1'b0;
        rd("lim_count_before", 4'd10, 32'd3);
        clk_en = 1'b1;
        wr(4'd8, 32'd5);
        clk_en = 1'b0;
        rd("lim_count_zeroed", 4'd10, 32'd0);
        rd("lim_no_pending", 4'd11, 32'd0);
        rd("lim_value", 4'd8, 32'd5);
        wr(4'd9, 32'd0);

        // Masking on ch0 (LIMIT=0, ie=0) with ch3 (LIMIT=7) running alongside
        wr(4'd12, 32'd7);
        wr(4'd0, 32'd0);
        wr(4'd1, 32'd3);
        wr(4'd13, 32'd7);
        clk_en = 1'b1;
        @(negedge clk);
        clk_en = 1'b0;
        rd("mask_pending", 4'd3, 32'd1);
        check("mask_irq_low", 32'(irq), 32'd0);
        check("mask_irq_vec_low", 32'(irq_vec), 32'd0);
        wr(4'd1, 32'd7);
        check("unmask_lag", 32'(irq), 32'd0);
        @(negedge clk);
        check("unmask_irq", 32'(irq), 32'd1);
        check("unmask_irq_vec", 32'(irq_vec), 32'h1);
        rd("ch3_count_1", 4'd14, 32'd1);
        clk_en = 1'b1;
        repeat (6) @(negedge clk);
        clk_en = 1'b0;
        rd("ch3_count_7", 4'd14, 32'd7);
        rd("ch3_not_pending", 4'd15, 32'd0);
        clk_en = 1'b1;
        @(negedge clk);
        clk_en = 1'b0;
        rd("ch3_pending", 4'd15, 32'd1);
        check("ch3_irq_vec", 32'(irq_vec), 32'h9);

        // Unmapped channel on the 3-channel build
        rd("ch0_ctrl", 4'd1, 32'h7);
        check("dut3_ch0_ctrl", rdata3, 32'h7);
        rd("ch3_ctrl", 4'd13, 32'h7);
        check("dut3_unmapped_rdata", rdata3, 32'd0);
        check("dut3_unmapped_rvalid", 32'(rvalid3), 32'd1);
        @(negedge clk);
        check("rvalid_idle", 32'(rvalid), 32'd0);
        check("rdata_hold", rdata, 32'h7);

        // Asynchronous reset mid-count
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_irq", 32'(irq), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_irq", 32'(irq), 32'd0);
        check("async_irq_vec", 32'(irq_vec), 32'd0);
        check("async_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd("post_reset_count", 4'd14, 32'd0);
        rd("post_reset_ctrl", 4'd13, 32'd0);
        repeat (10) @(negedge clk);
        rd("post_reset_idle_count", 4'd14, 32'd0);
        rd("post_reset_status", 4'd3, 32'd0);
        check("post_reset_irq", 32'(irq), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
